// File: rtl/prach_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prach_pkg
//  Description : Shared sizes and FSM encoding for the PRACH readout scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package prach_pkg;

    localparam int N_CC        = 3;
    localparam int N_ANT       = 8;
    localparam int N_CH        = N_CC * N_ANT;
    localparam int CH_W        = 5;
    localparam int BLK_LEN_DEF = 1536;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/prach_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : prach_rr_arbiter
//  Description : Combinational round-robin pick over the flat channel vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module prach_rr_arbiter
    import prach_pkg::*;
(
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] last_grant,
    output logic [N_CH-1:0] gnt,
    output logic [CH_W-1:0] idx,
    output logic            vld
);

    int              w_c;
    logic [CH_W-1:0] w_c5;

    // Walk last_grant+1 .. last_grant+N_CH (mod N_CH); first hit wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        vld  = 1'b0;
        w_c  = 0;
        w_c5 = '0;
        for (int i = 1; i <= N_CH; i++) begin
            w_c = int'(last_grant) + i;
            if (w_c >= N_CH) w_c = w_c - N_CH;
            w_c5 = CH_W'(w_c);
            if (!vld && req[w_c5]) begin
                vld       = 1'b1;
                idx       = w_c5;
                gnt[w_c5] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/prach_readout_sched.sv
`default_nettype none
// ============================================================================
//  Module      : prach_readout_sched
//  Description : Grants one full PRACH buffer at a time to the FFT, streams
//                its read addresses, then enforces an idle gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module prach_readout_sched
    import prach_pkg::*;
#(
    parameter int BLK_LEN    = BLK_LEN_DEF,
    parameter int GAP_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_CC-1:0][N_ANT-1:0]  done_req,
    output logic [N_CC-1:0][N_ANT-1:0]  done_ack,
    output logic [N_CC-1:0][N_ANT-1:0]  rd_en,
    output logic [10:0]                 rd_addr,
    input  logic [N_CC-1:0]             cc_en,
    input  logic                        fft_ready,
    output logic                        sof,
    output logic                        eof,
    output logic [CH_W-1:0]             ch_id,
    output logic                        busy,
    output logic [15:0]                 blk_cnt
);

    localparam int              c_GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [10:0]     c_ADDR_LAST = 11'(BLK_LEN - 1);
    localparam logic [c_GW-1:0] c_GAP_LAST  = c_GW'(GAP_CYCLES - 1);

    state_t          r_state;
    logic [N_CH-1:0] r_ack;
    logic [10:0]     r_addr;
    logic            r_sof;
    logic            r_eof;
    logic            r_busy;
    logic [CH_W-1:0] r_ch;
    logic [CH_W-1:0] r_last;
    logic [15:0]     r_blk;
    logic [c_GW-1:0] r_gap;

    logic [N_CH-1:0] w_req;
    logic [N_CH-1:0] w_cc_mask;
    logic [N_CH-1:0] w_gnt;
    logic [CH_W-1:0] w_idx;
    logic            w_vld;

    assign w_req = done_req;

    for (genvar g = 0; g < N_CC; g++) begin : g_cc_mask
        assign w_cc_mask[g*N_ANT +: N_ANT] = {N_ANT{cc_en[g]}};
    end

    prach_rr_arbiter u_arb (
        .req        (w_req & w_cc_mask),
        .last_grant (r_last),
        .gnt        (w_gnt),
        .idx        (w_idx),
        .vld        (w_vld)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ack   <= '0;
            r_addr  <= '0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
            r_busy  <= 1'b0;
            r_ch    <= '0;
            r_last  <= CH_W'(N_CH - 1);
            r_blk   <= '0;
            r_gap   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (fft_ready && w_vld) begin
                        r_state <= ST_READ;
                        r_ack   <= w_gnt;
                        r_ch    <= w_idx;
                        r_last  <= w_idx;
                        r_addr  <= '0;
                        r_sof   <= 1'b1;
                        r_eof   <= (c_ADDR_LAST == 11'd0);
                        r_busy  <= 1'b1;
                    end
                end
                ST_READ: begin
                    r_sof <= 1'b0;
                    if (r_addr == c_ADDR_LAST) begin
                        r_ack  <= '0;
                        r_addr <= '0;
                        r_eof  <= 1'b0;
                        r_blk  <= r_blk + 16'd1;
                        r_gap  <= '0;
                        if (GAP_CYCLES == 0) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_GAP;
                        end
                    end else begin
                        r_addr <= r_addr + 11'd1;
                        r_eof  <= (r_addr == c_ADDR_LAST - 11'd1);
                    end
                end
                ST_GAP: begin
                    if (r_gap == c_GAP_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign done_ack = r_ack;
    assign rd_en    = r_ack;
    assign rd_addr  = r_addr;
    assign sof      = r_sof;
    assign eof      = r_eof;
    assign busy     = r_busy;
    assign ch_id    = r_ch;
    assign blk_cnt  = r_blk;

endmodule
`default_nettype wire

// File: doc/prach_readout_sched.md
PRACH_READOUT_SCHED -- requirements
Module: prach_readout_sched

Interface
REQ-001 SHALL have parameter BLK_LEN, default 1536, samples read per block.
REQ-002 SHALL have parameter GAP_CYCLES, default 16, minimum idle cycles after each block.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 done_req  input  [3][8] x 1  per-(cc,ant) buffer-full request; held high until done_ack falls.
REQ-006 done_ack  output  [3][8] x 1  one-hot grant; high for the whole read of that buffer.
REQ-007 rd_en  output  [3][8] x 1  buffer read enable; equals done_ack.
REQ-008 rd_addr  output  11  sample read address.
REQ-009 cc_en  input  3  per-CC enable mask; requests from a disabled CC are ignored.
REQ-010 fft_ready  input  1  FFT can accept a new block.
REQ-011 sof / eof  output  1 each  first / last read cycle of a block.
REQ-012 ch_id  output  5  flat index cc*8+ant of the granted buffer; valid while busy.
REQ-013 busy  output  1  high in GRANT-to-GAP span (READ and GAP states).
REQ-014 blk_cnt  output  16  completed-block counter.

Function
REQ-015 SHALL implement FSM states IDLE, READ, GAP.
REQ-016 IDLE: when fft_ready=1 and any eligible request (done_req & cc_en) is present, SHALL grant one and enter READ next cycle; otherwise stay in IDLE.
REQ-017 fft_ready SHALL be sampled only in IDLE; deassertion during READ/GAP has no effect.
REQ-018 Arbitration SHALL be round-robin over the 24 flat indices: search starts at last_grant+1 mod 24; first eligible index wins.
REQ-019 last_grant SHALL update only on a grant.
REQ-020 Grant latency: request seen in IDLE at cycle t -> done_ack/rd_en one-hot high, rd_addr=0, sof=1 at t+1.
REQ-021 READ: rd_addr SHALL increment by 1 per cycle from 0 to BLK_LEN-1 with no stalls.
REQ-022 eof SHALL be 1 exactly when rd_addr=BLK_LEN-1 in READ; the next cycle SHALL be GAP with done_ack/rd_en all 0.
REQ-023 GAP: SHALL last exactly GAP_CYCLES cycles, then return to IDLE; requests are not granted during GAP.
REQ-024 GAP_CYCLES=0 SHALL skip GAP (READ -> IDLE directly).
REQ-025 blk_cnt SHALL increment on each eof, wrapping 65535 -> 0.
REQ-026 cc_en changes mid-READ SHALL not abort the active block.
REQ-027 rd_addr SHALL be 0 outside READ; sof, eof 0 outside READ.
REQ-028 At most one done_ack bit SHALL be high in any cycle.

Reset
REQ-029 On rst_n=0 (any state, including mid-READ) next cycle: state IDLE, done_ack/rd_en all 0, rd_addr=0, sof=eof=busy=0, ch_id=0, blk_cnt=0.
REQ-030 Reset SHALL set last_grant=23 so index 0 has highest priority first.

Structure
REQ-031 Package prach_pkg SHALL hold N_CC=3, N_ANT=8, N_CH=24, BLK_LEN default, and the FSM state enum.
REQ-032 Round-robin selection SHALL be a sub-module prach_rr_arbiter (N_CH request vector, last_grant in, one-hot grant and index out, combinational).

Verification
REQ-033 Single req cc0/ant5, fft_ready=1 -> ack[0][5] next cycle, ch_id=5, rd_addr 0..1535, eof at 1535, 16 GAP cycles, blk_cnt=1.
REQ-034 All 24 requests held after reset -> grant order 0,1,...,23, then 0 again.
REQ-035 After grant of index 5 completes, requests at 3 and 7 -> 7 granted before 3.
REQ-036 fft_ready=0 with pending request -> stays IDLE, no ack; raise fft_ready -> grant next cycle.
REQ-037 cc_en=3'b101, only cc1 requests -> no grant; set cc_en=3'b111 -> grant.
REQ-038 rst_n pulse at rd_addr=100 -> all outputs zero next cycle; subsequent requests 0 and 9 -> 0 granted first.
